// File: rtl/csync_gen_pkg.sv
// Shared timing defaults and half-line classification for the PAL composite sync generator.
package csync_gen_pkg;

    localparam int DEF_LINE_CLKS  = 6400;
    localparam int DEF_HSYNC_CLKS = 470;
    localparam int DEF_EQ_CLKS    = 235;
    localparam int DEF_BROAD_CLKS = 2730;

    localparam logic [9:0] LINES_INTERLACED  = 10'd625;
    localparam logic [9:0] LINES_PROGRESSIVE = 10'd312;

    typedef enum logic [1:0] {
        HT_NONE   = 2'd0,
        HT_NORMAL = 2'd1,
        HT_EQ     = 2'd2,
        HT_BROAD  = 2'd3
    } half_type_t;

endpackage

// File: rtl/csync_halfline_decode.sv
// Maps (line number, half of line, field mode) to the sync pulse type of that half-line.
module csync_halfline_decode
    import csync_gen_pkg::*;
(
    input  logic       [9:0] line_num,
    input  logic             second_half,
    input  logic             progressive,
    output half_type_t       half_type
);

    half_type_t first_type;
    half_type_t second_type;

    always_comb begin
        first_type  = HT_NONE;
        second_type = HT_NONE;
        case (line_num) inside
            [10'd1:10'd2]: begin
                first_type  = HT_BROAD;
                second_type = HT_BROAD;
            end
            10'd3: begin
                first_type  = HT_BROAD;
                second_type = HT_EQ;
            end
            [10'd4:10'd5]: begin
                first_type  = HT_EQ;
                second_type = HT_EQ;
            end
            [10'd6:10'd310]: begin
                first_type  = HT_NORMAL;
                second_type = HT_NONE;
            end
            [10'd311:10'd312]: begin
                first_type  = HT_EQ;
                second_type = HT_EQ;
            end
            10'd313: begin
                first_type  = HT_EQ;
                second_type = HT_BROAD;
            end
            [10'd314:10'd315]: begin
                first_type  = HT_BROAD;
                second_type = HT_BROAD;
            end
            [10'd316:10'd317]: begin
                first_type  = HT_EQ;
                second_type = HT_EQ;
            end
            10'd318: begin
                first_type  = HT_EQ;
                second_type = HT_NONE;
            end
            [10'd319:10'd622]: begin
                first_type  = HT_NORMAL;
                second_type = HT_NONE;
            end
            10'd623: begin
                first_type  = HT_NORMAL;
                second_type = HT_EQ;
            end
            [10'd624:10'd625]: begin
                first_type  = HT_EQ;
                second_type = HT_EQ;
            end
            default: begin
                first_type  = HT_NONE;
                second_type = HT_NONE;
            end
        endcase

        // A progressive frame ends at line 312, so the second-field lines carry no pulses.
        if (progressive && (line_num > LINES_PROGRESSIVE)) begin
            first_type  = HT_NONE;
            second_type = HT_NONE;
        end
    end

    assign half_type = second_half ? second_type : first_type;

endmodule

// File: rtl/csync_generator.sv
// PAL composite sync generator: 625-line interlaced frame by default,
// 312-line progressive frame when CSYNC_GEN_PROGRESSIVE_EN is defined.
module csync_generator
    import csync_gen_pkg::*;
#(
    parameter int LINE_CLKS  = DEF_LINE_CLKS,
    parameter int HSYNC_CLKS = DEF_HSYNC_CLKS,
    parameter int EQ_CLKS    = DEF_EQ_CLKS,
    parameter int BROAD_CLKS = DEF_BROAD_CLKS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        csync_n,
    output logic        vsync_n,
    output logic        field,
    output logic [9:0]  line_num,
    output logic [12:0] h_count
);

`ifdef CSYNC_GEN_PROGRESSIVE_EN
    localparam logic       PROGRESSIVE_MODE = 1'b1;
    localparam logic [9:0] LAST_LINE        = LINES_PROGRESSIVE;
`else
    localparam logic       PROGRESSIVE_MODE = 1'b0;
    localparam logic [9:0] LAST_LINE        = LINES_INTERLACED;
`endif

    localparam logic [12:0] H_LAST     = 13'(LINE_CLKS - 1);
    localparam logic [12:0] HALF_CLKS  = 13'(LINE_CLKS / 2);
    localparam logic [12:0] HSYNC_LEN  = 13'(HSYNC_CLKS);
    localparam logic [12:0] EQ_LEN     = 13'(EQ_CLKS);
    localparam logic [12:0] BROAD_LEN  = 13'(BROAD_CLKS);

    logic [12:0] h_count_reg;
    logic [12:0] h_count_next;
    logic [9:0]  line_num_reg;
    logic [9:0]  line_num_next;
    logic        csync_n_reg;
    logic        csync_n_next;
    logic        vsync_n_reg;
    logic        vsync_n_next;

    logic        second_half;
    logic [12:0] half_offset;
    logic [12:0] pulse_len;
    half_type_t  half_type;

    assign second_half = (h_count_reg >= HALF_CLKS);
    assign half_offset = second_half ? (h_count_reg - HALF_CLKS) : h_count_reg;

    csync_halfline_decode u_decode (
        .line_num    (line_num_reg),
        .second_half (second_half),
        .progressive (PROGRESSIVE_MODE),
        .half_type   (half_type)
    );

    always_comb begin
        pulse_len = 13'd0;
        case (half_type)
            HT_NORMAL: pulse_len = HSYNC_LEN;
            HT_EQ:     pulse_len = EQ_LEN;
            HT_BROAD:  pulse_len = BROAD_LEN;
            default:   pulse_len = 13'd0;
        endcase
    end

    always_comb begin
        h_count_next  = h_count_reg;
        line_num_next = line_num_reg;
        if (enable) begin
            if (h_count_reg == H_LAST) begin
                h_count_next  = 13'd0;
                line_num_next = (line_num_reg == LAST_LINE) ? 10'd1 : (line_num_reg + 10'd1);
            end else begin
                h_count_next = h_count_reg + 13'd1;
            end
        end
    end

    // Broad half-lines coincide exactly with the vertical sync interval of each field.
    always_comb begin
        csync_n_next = 1'b1;
        vsync_n_next = 1'b1;
        if (enable) begin
            csync_n_next = !(half_offset < pulse_len);
            vsync_n_next = (half_type != HT_BROAD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count_reg  <= 13'd0;
            line_num_reg <= 10'd1;
            csync_n_reg  <= 1'b1;
            vsync_n_reg  <= 1'b1;
        end else begin
            h_count_reg  <= h_count_next;
            line_num_reg <= line_num_next;
            csync_n_reg  <= csync_n_next;
            vsync_n_reg  <= vsync_n_next;
        end
    end

`ifdef CSYNC_GEN_PROGRESSIVE_EN
    assign field = 1'b0;
`else
    // Second field starts half way through line 313.
    assign field = (line_num_reg > 10'd313) || ((line_num_reg == 10'd313) && second_half);
`endif

    assign csync_n  = csync_n_reg;
    assign vsync_n  = vsync_n_reg;
    assign line_num = line_num_reg;
    assign h_count  = h_count_reg;

endmodule

// File: tb/tb_csync_generator.sv
// Scoreboard bench: one default-timing instance and one scaled-timing instance share the stimulus.
module tb_csync_generator;

`ifdef CSYNC_GEN_PROGRESSIVE_EN
    localparam bit PROG      = 1'b1;
    localparam int LAST      = 312;
    localparam int EXP_FALLS = 319;
`else
    localparam bit PROG      = 1'b0;
    localparam int LAST      = 625;
    localparam int EXP_FALLS = 640;
`endif

    localparam int LA = 6400, HA = 470, EA = 235, BA = 2730;
    localparam int LB = 64,   HB = 5,   EB = 2,   BB = 27;
    localparam int FRAME_B = LAST * LB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic        csync_n_a, vsync_n_a, field_a;
    logic [9:0]  line_num_a;
    logic [12:0] h_count_a;
    logic        csync_n_b, vsync_n_b, field_b;
    logic [9:0]  line_num_b;
    logic [12:0] h_count_b;

    always #5 clk = ~clk;

    csync_generator u_dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .csync_n(csync_n_a), .vsync_n(vsync_n_a), .field(field_a),
        .line_num(line_num_a), .h_count(h_count_a)
    );

    csync_generator #(.LINE_CLKS(LB), .HSYNC_CLKS(HB), .EQ_CLKS(EB), .BROAD_CLKS(BB)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .csync_n(csync_n_b), .vsync_n(vsync_n_b), .field(field_b),
        .line_num(line_num_b), .h_count(h_count_b)
    );

    typedef struct {
        bit ca; bit va; bit fa; int ha; int la;
        bit cb; bit vb; bit fb; int hb; int lb;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int ma_h = 0, ma_line = 1, mb_h = 0, mb_line = 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
            if (n_fail >= 200) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    endtask

    // 0 none, 1 normal, 2 equalising, 3 broad
    function automatic int half_kind(input int line, input bit second);
        if (PROG && line > 312) return 0;
        if (line <= 2)   return 3;
        if (line == 3)   return second ? 2 : 3;
        if (line <= 5)   return 2;
        if (line <= 310) return second ? 0 : 1;
        if (line <= 312) return 2;
        if (line == 313) return second ? 3 : 2;
        if (line <= 315) return 3;
        if (line <= 317) return 2;
        if (line == 318) return second ? 0 : 2;
        if (line <= 622) return second ? 0 : 1;
        if (line == 623) return second ? 2 : 1;
        return 2;
    endfunction

    function automatic bit exp_csync(input int line, input int h, input int l, input int hs, input int eq, input int br);
        bit second = (h >= l / 2);
        int off = second ? h - l / 2 : h;
        int k = half_kind(line, second);
        int w = (k == 1) ? hs : (k == 2) ? eq : (k == 3) ? br : 0;
        return !(off < w);
    endfunction

    function automatic bit exp_vsync(input int line, input int h, input int l);
        int pos = (line - 1) * l + h;
        if (pos < (5 * l) / 2) return 1'b0;
        if (!PROG && pos >= (625 * l) / 2 && pos < 315 * l) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_field(input int line, input int h, input int l);
        int pos = (line - 1) * l + h;
        return !PROG && (pos >= (625 * l) / 2);
    endfunction

    task automatic predict(input int l, input int hs, input int eq, input int br, input bit rst, input bit en,
                           inout int h, inout int line, output bit c, output bit v);
        if (rst) begin
            h = 0; line = 1; c = 1'b1; v = 1'b1;
        end else if (!en) begin
            c = 1'b1; v = 1'b1;
        end else begin
            c = exp_csync(line, h, l, hs, eq, br);
            v = exp_vsync(line, h, l);
            h++;
            if (h == l) begin
                h = 0;
                line = (line == LAST) ? 1 : line + 1;
            end
        end
    endtask

    task automatic tick(input bit rst, input bit en);
        exp_t e;
        @(negedge clk);
        reset = rst;
        enable = en;
        predict(LA, HA, EA, BA, rst, en, ma_h, ma_line, e.ca, e.va);
        e.ha = ma_h; e.la = ma_line; e.fa = exp_field(ma_line, ma_h, LA);
        predict(LB, HB, EB, BB, rst, en, mb_h, mb_line, e.cb, e.vb);
        e.hb = mb_h; e.lb = mb_line; e.fb = exp_field(mb_line, mb_h, LB);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("csync_a", int'(csync_n_a), int'(e.ca));
        check_eq("vsync_a", int'(vsync_n_a), int'(e.va));
        check_eq("field_a", int'(field_a), int'(e.fa));
        check_eq("hcnt_a", int'(h_count_a), e.ha);
        check_eq("line_a", int'(line_num_a), e.la);
        check_eq("csync_b", int'(csync_n_b), int'(e.cb));
        check_eq("vsync_b", int'(vsync_n_b), int'(e.vb));
        check_eq("field_b", int'(field_b), int'(e.fb));
        check_eq("hcnt_b", int'(h_count_b), e.hb);
        check_eq("line_b", int'(line_num_b), e.lb);
    endtask

    initial begin
        int n;
        int falls;
        int a_low;
        int low_run;
        bit prev;

        repeat (3) tick(1'b1, 1'b0);
        check_eq("rst_csync", int'(csync_n_b), 1);
        check_eq("rst_line", int'(line_num_b), 1);
        $display("reset done: h_count=%0d line_num=%0d", h_count_a, line_num_a);

        n = 0; falls = 0; a_low = 0; prev = 1'b1;
        do begin
            tick(1'b0, 1'b1);
            n++;
            if (prev && !csync_n_b) falls++;
            prev = csync_n_b;
            if (n <= 3200 && !csync_n_a) a_low++;
            if (n == 3201) check_eq("a_broad2_start", int'(csync_n_a), 0);
            if (!PROG && n == 312 * LB + LB / 2 + 1) begin
                check_eq("b_vsync_313", int'(vsync_n_b), 0);
                check_eq("b_field_313", int'(field_b), 1);
            end
        end while (!(line_num_b == 10'd1 && h_count_b == 13'd0) && n < FRAME_B + 10);
        check_eq("a_broad1_len", a_low, BA);
        check_eq("frame_len", n, FRAME_B);
        check_eq("frame_falls", falls, EXP_FALLS);
        check_eq("wrap_field", int'(field_b), 0);
        $display("frame done: %0d clocks, %0d csync falls", n, falls);

        repeat (10) tick(1'b0, 1'b1);
        repeat (1000) tick(1'b0, 1'b0);
        check_eq("pause_hold_h", int'(h_count_b), 10);
        check_eq("pause_csync", int'(csync_n_b), 1);
        low_run = 0;
        n = 0;
        do begin
            tick(1'b0, 1'b1);
            n++;
            if (!csync_n_b) low_run++;
        end while (!csync_n_b && n < 100);
        check_eq("resume_low", low_run, BB - 10);
        $display("pause done: resumed pulse low for %0d clocks", low_run);

        repeat (5) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check_eq("midrst_csync", int'(csync_n_b), 1);
        tick(1'b0, 1'b1);
        check_eq("post_rst_csync", int'(csync_n_a), 0);
        check_eq("post_rst_h", int'(h_count_a), 1);
        repeat (3) tick(1'b0, 1'b1);
        $display("mid-line reset done: h_count=%0d", h_count_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
